// File: rtl/stacking_outer_loop_pkg.sv
// Layer geometry, derived widths and the outer-loop state encoding shared by
// the stacking outer-loop sequencer and its bus interface.
package stacking_outer_loop_pkg;

    localparam int unsigned LAYER_IFM_SIZE_Y    = 6;
    localparam int unsigned LAYER_FILTER_SIZE_Y = 3;
    localparam int unsigned LAYER_OUTPUT_SIZE_Y = 4;
    localparam int unsigned LAYER_FILTER_SIZE_X = 3;

    // Row counter must be able to hold IFM_Y itself, not just IFM_Y-1.
    localparam int unsigned Y_W = $clog2(LAYER_IFM_SIZE_Y + 1);

    // A valid-convolution geometry is required; users elaborate a check on it.
    localparam bit GEOMETRY_OK =
        (LAYER_IFM_SIZE_Y == LAYER_OUTPUT_SIZE_Y + LAYER_FILTER_SIZE_Y - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

endpackage

// File: rtl/stacking_outer_loop_if.sv
// Handshake and operand bundle between the outer-loop sequencer (slave) and
// the controller, IFM loader, inner loop and write-out logic (master).
interface stacking_outer_loop_if;

    logic        start_i;
    logic [31:0] sub_channel_size_i;
    logic        ifm_load_req_o;
    logic        ifm_load_done_i;
    logic        inner_loop_start_o;
    logic        inner_loop_finish_i;
    logic [31:0] ifm_loop_y_idx_o;
    logic [31:0] fil_loop_y_idx_start_o;
    logic [31:0] fil_loop_y_idx_last_o;
    logic [31:0] fil_loop_y_step_o;
    logic [31:0] sub_channel_size_o;
    logic        drain_req_o;
    logic [31:0] drain_row_o;
    logic        drain_ack_i;
    logic        busy_o;
    logic        done_o;

    modport master (
        output start_i,
        output sub_channel_size_i,
        input  ifm_load_req_o,
        output ifm_load_done_i,
        input  inner_loop_start_o,
        output inner_loop_finish_i,
        input  ifm_loop_y_idx_o,
        input  fil_loop_y_idx_start_o,
        input  fil_loop_y_idx_last_o,
        input  fil_loop_y_step_o,
        input  sub_channel_size_o,
        input  drain_req_o,
        input  drain_row_o,
        output drain_ack_i,
        input  busy_o,
        input  done_o
    );

    modport slave (
        input  start_i,
        input  sub_channel_size_i,
        output ifm_load_req_o,
        input  ifm_load_done_i,
        output inner_loop_start_o,
        input  inner_loop_finish_i,
        output ifm_loop_y_idx_o,
        output fil_loop_y_idx_start_o,
        output fil_loop_y_idx_last_o,
        output fil_loop_y_step_o,
        output sub_channel_size_o,
        output drain_req_o,
        output drain_row_o,
        input  drain_ack_i,
        output busy_o,
        output done_o
    );

endinterface

// File: rtl/stacking_outer_loop.sv
// Outer row loop of the stacking convolution: walks IFM rows, launches the
// inner loop per row with its filter-row window, and drains finished output rows.
module stacking_outer_loop
    import stacking_outer_loop_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    stacking_outer_loop_if.slave bus
);

    if (!GEOMETRY_OK) begin : g_geometry_check
        $error("stacking_outer_loop: IFM_Y must equal OUT_Y + FIL_Y - 1");
    end

    localparam logic [Y_W-1:0] FIL_LAST = Y_W'(LAYER_FILTER_SIZE_Y - 1);
    localparam logic [Y_W-1:0] OUT_LAST = Y_W'(LAYER_OUTPUT_SIZE_Y - 1);
    localparam logic [Y_W-1:0] Y_LAST   = Y_W'(LAYER_IFM_SIZE_Y - 1);
    localparam logic [Y_W-1:0] Y_ONE    = Y_W'(1);

    state_e      state_q, state_d;
    logic [Y_W-1:0] y_q, y_d;
    logic [31:0] sub_size_q, sub_size_d;

    logic [Y_W-1:0] fil_start;
    logic [Y_W-1:0] fil_last;
    logic [Y_W-1:0] drain_row;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            y_q        <= '0;
            sub_size_q <= '0;
        end else begin
            state_q    <= state_d;
            y_q        <= y_d;
            sub_size_q <= sub_size_d;
        end
    end

    // Handshake inputs are only looked at in the state that owns them, so
    // stray pulses elsewhere fall through the default hold.
    always_comb begin
        state_d    = state_q;
        y_d        = y_q;
        sub_size_d = sub_size_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    state_d    = ST_LOAD;
                    y_d        = '0;
                    sub_size_d = bus.sub_channel_size_i;
                end
            end
            ST_LOAD: begin
                if (bus.ifm_load_done_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.inner_loop_finish_i) begin
                    if (y_q >= FIL_LAST) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_LOAD;
                        y_d     = y_q + Y_ONE;
                    end
                end
            end
            ST_DRAIN: begin
                if (bus.drain_ack_i) begin
                    if (y_q == Y_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_LOAD;
                        y_d     = y_q + Y_ONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Window math compares before subtracting so the unsigned counter never wraps.
    always_comb begin
        fil_start = '0;
        fil_last  = y_q;
        drain_row = '0;
        if (y_q > OUT_LAST) begin
            fil_start = y_q - OUT_LAST;
        end
        if (y_q > FIL_LAST) begin
            fil_last = FIL_LAST;
        end
        if (y_q >= FIL_LAST) begin
            drain_row = y_q - FIL_LAST;
        end
    end

    always_comb begin
        bus.ifm_load_req_o         = (state_q == ST_LOAD);
        bus.inner_loop_start_o     = (state_q == ST_RUN);
        bus.drain_req_o            = (state_q == ST_DRAIN);
        bus.done_o                 = (state_q == ST_DONE);
        bus.busy_o                 = (state_q != ST_IDLE);
        bus.ifm_loop_y_idx_o       = 32'(y_q);
        bus.fil_loop_y_idx_start_o = 32'(fil_start);
        bus.fil_loop_y_idx_last_o  = 32'(fil_last);
        bus.drain_row_o            = 32'(drain_row);
        bus.fil_loop_y_step_o      = 32'(LAYER_FILTER_SIZE_X);
        bus.sub_channel_size_o     = sub_size_q;
    end

endmodule
